// File: rtl/fractal_pkg.sv
// Shared constants, state type and fixed-point helpers for the Mandelbrot
// iteration engine. Numbers are two's-complement 4.23 fixed point.
package fractal_pkg;

  localparam int WIDTH  = 27;
  localparam int FRAC   = 23;
  localparam int ITER_W = 10;

  localparam logic signed [WIDTH-1:0] FX_TWO  = 27'h100_0000;
  localparam logic signed [WIDTH-1:0] FX_FOUR = 27'h200_0000;
  localparam logic signed [WIDTH-1:0] FX_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] FX_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    MXX,
    MYY,
    MXY,
    UPD,
    DONE
  } iter_state_t;

  // Clamp a WIDTH+2 bit intermediate sum back into the WIDTH-bit range.
  function automatic logic signed [WIDTH-1:0] fx_sat(input logic signed [WIDTH+1:0] v);
    if (v > (WIDTH+2)'(FX_MAX)) begin
      return FX_MAX;
    end else if (v < (WIDTH+2)'(FX_MIN)) begin
      return FX_MIN;
    end else begin
      return v[WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/mandel_iter_ctrl_if.sv
// Start/done handshake bundle between the pixel scheduler, the iteration
// engine and the colour mapper.
interface mandel_iter_ctrl_if;
  import fractal_pkg::*;

  logic                     start_valid;
  logic                     start_ready;
  logic signed [WIDTH-1:0]  c_re;
  logic signed [WIDTH-1:0]  c_im;
  logic [ITER_W-1:0]        max_iter;
  logic                     done_valid;
  logic                     done_ready;
  logic [ITER_W-1:0]        iter_count;
  logic                     escaped;
  logic                     busy;

  // Engine side.
  modport slave (
    input  start_valid, c_re, c_im, max_iter, done_ready,
    output start_ready, done_valid, iter_count, escaped, busy
  );

  // Scheduler / colour-mapper side.
  modport master (
    output start_valid, c_re, c_im, max_iter, done_ready,
    input  start_ready, done_valid, iter_count, escaped, busy
  );

endinterface

// File: rtl/signed_mult.sv
// Plain combinational signed multiplier, full-width product.
module signed_mult #(
  parameter int W = 27
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);

  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] b_ext;

  // Sign-extend both operands so the multiply is done at full product width.
  always_comb begin
    a_ext = (2*W)'(a);
    b_ext = (2*W)'(b);
    p     = a_ext * b_ext;
  end

endmodule

// File: rtl/mandel_iter_ctrl.sv
// Mandelbrot per-pixel iteration engine: z <- z^2 + c from z = 0, sharing a
// single multiplier across x*x, y*y and x*y. Reports the iteration count and
// whether the point escaped.
module mandel_iter_ctrl
  import fractal_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mandel_iter_ctrl_if.slave  bus
);

  iter_state_t              state_q, state_d;
  logic signed [WIDTH-1:0]  c_re_q, c_re_d;
  logic signed [WIDTH-1:0]  c_im_q, c_im_d;
  logic [ITER_W-1:0]        max_iter_q, max_iter_d;
  logic signed [WIDTH-1:0]  x_q, x_d;
  logic signed [WIDTH-1:0]  y_q, y_d;
  logic signed [WIDTH-1:0]  xx_q, xx_d;
  logic signed [WIDTH-1:0]  yy_q, yy_d;
  logic signed [WIDTH-1:0]  xy_q, xy_d;
  logic [ITER_W-1:0]        count_q, count_d;
  logic [ITER_W-1:0]        iter_count_q, iter_count_d;
  logic                     escaped_q, escaped_d;

  logic signed [WIDTH-1:0]   mul_a;
  logic signed [WIDTH-1:0]   mul_b;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   prod_fx;
  logic                      prod_unused;
  logic signed [WIDTH:0]     s_sum;
  logic signed [WIDTH+1:0]   x_sum;
  logic signed [WIDTH+1:0]   y_sum;
  logic                      out_of_range;

  signed_mult #(.W(WIDTH)) u_mult (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // Operand mux: the multiplier only sees live operands in the three product
  // states, otherwise it is fed zeros so the product is zero.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MXX:     begin mul_a = x_q; mul_b = x_q; end
      MYY:     begin mul_a = y_q; mul_b = y_q; end
      MXY:     begin mul_a = x_q; mul_b = y_q; end
      default: begin mul_a = '0;  mul_b = '0;  end
    endcase
  end

  // Rescale the 8.46 product to 4.23 and form the magnitude / update sums.
  // Operands are within +/-2.0, so the product fits in 4.23 and the bits
  // above bit 49 are pure sign copies; taking the top sign bit plus [48:23]
  // is the arithmetic shift right by FRAC.
  always_comb begin
    prod_fx      = {prod[2*WIDTH-1], prod[FRAC+WIDTH-2:FRAC]};
    prod_unused  = ^{prod[2*WIDTH-2:FRAC+WIDTH-1], prod[FRAC-1:0]};
    s_sum        = (WIDTH+1)'(xx_q) + (WIDTH+1)'(yy_q);
    x_sum        = (WIDTH+2)'(xx_q) - (WIDTH+2)'(yy_q) + (WIDTH+2)'(c_re_q);
    y_sum        = ((WIDTH+2)'(xy_q) <<< 1) + (WIDTH+2)'(c_im_q);
    out_of_range = (x_q > FX_TWO) || (x_q < -FX_TWO) ||
                   (y_q > FX_TWO) || (y_q < -FX_TWO);
  end

  // Next-state and datapath update for the iteration sequence.
  always_comb begin
    state_d      = state_q;
    c_re_d       = c_re_q;
    c_im_d       = c_im_q;
    max_iter_d   = max_iter_q;
    x_d          = x_q;
    y_d          = y_q;
    xx_d         = xx_q;
    yy_d         = yy_q;
    xy_d         = xy_q;
    count_d      = count_q;
    iter_count_d = iter_count_q;
    escaped_d    = escaped_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          c_re_d     = bus.c_re;
          c_im_d     = bus.c_im;
          max_iter_d = bus.max_iter;
          x_d        = '0;
          y_d        = '0;
          count_d    = '0;
          state_d    = CHK;
        end
      end
      CHK: begin
        if (count_q == max_iter_q) begin
          iter_count_d = count_q;
          escaped_d    = 1'b0;
          state_d      = DONE;
        end else if (out_of_range) begin
          iter_count_d = count_q;
          escaped_d    = 1'b1;
          state_d      = DONE;
        end else begin
          state_d = MXX;
        end
      end
      MXX: begin
        xx_d    = prod_fx;
        state_d = MYY;
      end
      MYY: begin
        yy_d    = prod_fx;
        state_d = MXY;
      end
      MXY: begin
        xy_d = prod_fx;
        if (s_sum > (WIDTH+1)'(FX_FOUR)) begin
          iter_count_d = count_q;
          escaped_d    = 1'b1;
          state_d      = DONE;
        end else begin
          state_d = UPD;
        end
      end
      UPD: begin
        x_d     = fx_sat(x_sum);
        y_d     = fx_sat(y_sum);
        count_d = count_q + 1'b1;
        state_d = CHK;
      end
      DONE: begin
        if (bus.done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any point in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      c_re_q       <= '0;
      c_im_q       <= '0;
      max_iter_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      xx_q         <= '0;
      yy_q         <= '0;
      xy_q         <= '0;
      count_q      <= '0;
      iter_count_q <= '0;
      escaped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_re_q       <= c_re_d;
      c_im_q       <= c_im_d;
      max_iter_q   <= max_iter_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xx_q         <= xx_d;
      yy_q         <= yy_d;
      xy_q         <= xy_d;
      count_q      <= count_d;
      iter_count_q <= iter_count_d;
      escaped_q    <= escaped_d;
    end
  end

  // Status outputs decode directly from registered state; start_ready is
  // additionally held low while reset is asserted.
  always_comb begin
    bus.start_ready = rst_n && (state_q == IDLE);
    bus.busy        = (state_q != IDLE);
    bus.done_valid  = (state_q == DONE);
    bus.iter_count  = iter_count_q;
    bus.escaped     = escaped_q;
  end

endmodule
